// File: rtl/gift_round_sequencer.sv
// Iterative GIFT round controller: holds cipher and key state, steps an external
// combinational round datapath ROUNDS times per block, then presents the ciphertext.
module gift_round_sequencer #(
   parameter int ROUNDS  = 40,
   parameter int STATE_W = 64,
   parameter int KEY_W   = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_plaintext,
   input  logic [KEY_W-1:0]   in_key,
   output logic [STATE_W-1:0] dp_state_o,
   output logic [KEY_W-1:0]   dp_key_o,
   output logic [5:0]         dp_round_o,
   input  logic [STATE_W-1:0] dp_state_i,
   input  logic [KEY_W-1:0]   dp_key_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_ciphertext,
   output logic               busy
);

   // state | meaning
   // IDLE  | waiting for a block, in_ready high
   // RUN   | one datapath round per cycle, cnt_q is the round index
   // DONE  | ciphertext held on out_ciphertext until out_ready

   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [STATE_W-1:0] st_q;
   logic [KEY_W-1:0]   key_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   // Datapath inputs are only sampled in RUN so X outside RUN never reaches st_q/key_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         st_q        <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  st_q       <= in_plaintext;
                  key_q      <= in_key;
                  cnt_q      <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               st_q  <= dp_state_i;
               key_q <= dp_key_i;
               if (cnt_q == LAST_ROUND) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign busy           = busy_q;
   assign out_ciphertext = st_q;
   assign dp_state_o     = st_q;
   assign dp_key_o       = key_q;
   assign dp_round_o     = cnt_q;

endmodule

// File: tb/tb_gift_round_sequencer.sv
// Directed bench for gift_round_sequencer: stub and GIFT-64 datapaths, backpressure,
// back-to-back blocks, mid-run reset and a single-round build.
module tb_gift_round_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode_gift;

   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [63:0]  in_plaintext, dp_state_o, dp_state_i, out_ciphertext;
   logic [127:0] in_key, dp_key_o, dp_key_i;
   logic [5:0]   dp_round_o;

   logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [63:0]  in_plaintext1, dp_state_o1, dp_state_i1, out_ciphertext1;
   logic [127:0] dp_key_o1, dp_key_i1;
   logic [5:0]   dp_round_o1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] gift_round(input logic [63:0] s_in, input logic [127:0] k,
                                              input logic [5:0] r);
      logic [63:0] sbox_tbl;
      logic [63:0] s;
      logic [63:0] p;
      logic [5:0]  c;
      int          dst;
      sbox_tbl = 64'he8057bd293f6c4a1;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_tbl[4*int'(s_in[4*n +: 4]) +: 4];
      p = '0;
      for (int i = 0; i < 64; i++) begin
         dst = 4*(i/16) + 16*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
         p[dst] = s[i];
      end
      for (int i = 0; i < 16; i++) begin
         p[4*i+1] = p[4*i+1] ^ k[16+i];
         p[4*i]   = p[4*i]   ^ k[i];
      end
      c = '0;
      for (int j = 0; j <= int'(r); j++) c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      p[63] = ~p[63];
      p[23] = p[23] ^ c[5];
      p[19] = p[19] ^ c[4];
      p[15] = p[15] ^ c[3];
      p[11] = p[11] ^ c[2];
      p[7]  = p[7]  ^ c[1];
      p[3]  = p[3]  ^ c[0];
      return p;
   endfunction

   function automatic logic [127:0] gift_key_update(input logic [127:0] k);
      logic [15:0] k1, k0;
      k1 = k[31:16];
      k0 = k[15:0];
      return {{k1[1:0], k1[15:2]}, {k0[11:0], k0[15:12]}, k[127:32]};
   endfunction

   // Datapath drives X whenever the sequencer should not be sampling it.
   logic run40;
   assign run40      = busy && !out_valid;
   assign dp_state_i = !run40 ? {64{1'bx}} :
                       (mode_gift ? gift_round(dp_state_o, dp_key_o, dp_round_o) : dp_state_o + 64'd1);
   assign dp_key_i   = !run40 ? {128{1'bx}} :
                       (mode_gift ? gift_key_update(dp_key_o) : dp_key_o);
   assign dp_state_i1 = dp_state_o1 + 64'd1;
   assign dp_key_i1   = dp_key_o1;

   gift_round_sequencer #(.ROUNDS(40), .STATE_W(64), .KEY_W(128)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_plaintext(in_plaintext), .in_key(in_key),
      .dp_state_o(dp_state_o), .dp_key_o(dp_key_o), .dp_round_o(dp_round_o),
      .dp_state_i(dp_state_i), .dp_key_i(dp_key_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ciphertext(out_ciphertext), .busy(busy)
   );

   gift_round_sequencer #(.ROUNDS(1), .STATE_W(64), .KEY_W(128)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_plaintext(in_plaintext1), .in_key(128'h1),
      .dp_state_o(dp_state_o1), .dp_key_o(dp_key_o1), .dp_round_o(dp_round_o1),
      .dp_state_i(dp_state_i1), .dp_key_i(dp_key_i1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_ciphertext(out_ciphertext1), .busy(busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           cyc;
      logic [63:0]  model_st;
      logic [127:0] model_key;
      logic [63:0]  held_ct;
      logic         stable;
      logic [63:0]  ct_a;

      rst = 1'b1; mode_gift = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_plaintext = '0; in_key = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; in_plaintext1 = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ct", out_ciphertext, 0);

      // 1) stub datapath, latency
      in_plaintext = 64'h0; in_key = 128'hA5A5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_busy_after_accept", busy, 1);
      check("t1_in_ready_run", in_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 100) begin tick(); cyc++; end
      check("t1_latency", cyc, 40);
      check("t1_ct", out_ciphertext, 64'h28);
      check("t1_in_ready_done", in_ready, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_back_idle_ready", in_ready, 1);
      check("t1_back_idle_busy", busy, 0);

      // 2) GIFT reference datapath with round index tracking
      mode_gift = 1'b1;
      in_plaintext = 64'hFEDCBA9876543210;
      in_key = 128'h0123456789ABCDEF0123456789ABCDEF;
      model_st = in_plaintext; model_key = in_key;
      for (int r = 0; r < 40; r++) begin
         model_st  = gift_round(model_st, model_key, 6'(r));
         model_key = gift_key_update(model_key);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int r = 0; r < 40; r++) begin
         check($sformatf("t2_round_%0d", r), dp_round_o, r);
         tick();
      end
      check("t2_out_valid", out_valid, 1);
      check("t2_ct", out_ciphertext, model_st);
      check("t2_key", dp_key_o, model_key);

      // 3) backpressure in DONE
      held_ct = out_ciphertext;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(out_valid === 1'b1 && out_ciphertext === held_ct && in_ready === 1'b0)) stable = 1'b0;
      end
      check("t3_stable_under_backpressure", stable, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_in_ready_after_hs", in_ready, 1);
      check("t3_out_valid_after_hs", out_valid, 0);
      mode_gift = 1'b0;

      // 4) in_valid held, two blocks back to back
      out_ready = 1'b1;
      in_plaintext = 64'h1000; in_valid = 1'b1;
      tick();
      in_plaintext = 64'h2000;
      ct_a = '0;
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick(); cyc++;
         if (out_valid) ct_a = out_ciphertext;
      end
      tick(); cyc++;
      check("t4_b_accept_gap", cyc, 42);
      check("t4_ct_a", ct_a, 64'h1028);
      check("t4_busy_b", busy, 1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin tick(); cyc++; end
      check("t4_b_latency", cyc, 40);
      check("t4_ct_b", out_ciphertext, 64'h2028);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 5) reset at round 17
      in_plaintext = 64'h300; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (dp_round_o !== 6'd17 && cyc < 100) begin tick(); cyc++; end
      check("t5_reach_round17", dp_round_o, 17);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_in_ready", in_ready, 1);
      in_plaintext = 64'h400; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin tick(); cyc++; end
      check("t5_latency", cyc, 40);
      check("t5_ct", out_ciphertext, 64'h428);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 6) single-round build
      check("t6_ready", in_ready1, 1);
      in_plaintext1 = 64'h5; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      check("t6_run_no_valid", out_valid1, 0);
      tick();
      check("t6_valid", out_valid1, 1);
      check("t6_ct", out_ciphertext1, 64'h6);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("t6_idle", in_ready1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
